sad_pair_engine: RTL
====================

# sad_pair_engine

Computes two candidate sum-of-absolute-difference (SAD) values in parallel, window against frame position A and window against frame position B, over a fixed block of NPIX pixels. Each result is tagged with the candidate's 32-bit position/address and presented on a valid/ready handshake. The engine is the producer side of the SAD minimum tracker: its `SAD_value_small_A/B` and tag outputs drive the tracker's compare-and-store inputs. One `start` runs `num_pairs` consecutive candidate pairs with automatically advancing tags.

## Interface
- NPIX, 16, pixels per SAD block; legal range 2..32.
- TAG_STEP, 4, tag distance between adjacent candidates.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- tag_base  in  32  tag of the first A candidate; captured on start.
- num_pairs  in  8  number of candidate pairs in the run; captured on start.
- pix_valid  in  1  pixel triple valid.
- pix_ready  out  1  engine accepts a pixel triple.
- window_pix  in  8  reference window pixel, unsigned.
- frame_pix_A  in  8  frame pixel for candidate A, unsigned.
- frame_pix_B  in  8  frame pixel for candidate B, unsigned.
- sad_valid  out  1  result pair valid.
- sad_ready  in  1  consumer accepts the result pair.
- SAD_value_small_A  out  13  SAD of candidate A.
- SAD_value_small_B  out  13  SAD of candidate B.
- tag_A  out  32  tag of candidate A.
- tag_B  out  32  tag of candidate B; always tag_A + TAG_STEP.
- busy  out  1  high in ACCUM and OUT.
- done  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, ACCUM, OUT.
- IDLE: on `start`, capture `tag_base` into `tag_A` and `num_pairs` into the remaining-pairs counter. Clear both accumulators and the pixel counter.
  - If `num_pairs` is 0: stay in IDLE and pulse `done` next cycle. No result is produced.
  - Otherwise: go to ACCUM.
- ACCUM: `pix_ready`=1. Each accepted triple (`pix_valid & pix_ready`) does:
  - accA += |frame_pix_A − window_pix|
  - accB += |frame_pix_B − window_pix|
  - pixel counter += 1
  - Differences are 8-bit magnitudes. Accumulators are 13-bit. Maximum is 32×255 = 8160, so no overflow or saturation is possible.
  - On the NPIX-th accepted triple, go to OUT.
- OUT: `sad_valid`=1. `SAD_value_small_A/B` equal accA/accB; `tag_A/tag_B` are stable. `pix_ready`=0.
  - On `sad_valid & sad_ready`: decrement remaining pairs.
  - If pairs remain: `tag_A` += 2×TAG_STEP, clear accumulators and pixel counter, go to ACCUM.
  - Else: go to IDLE and pulse `done`.
- `start` is ignored outside IDLE.
- Tags wrap modulo 2^32.

## Timing
- Reset values: state IDLE, `pix_ready` 0, `sad_valid` 0, `busy` 0, `done` 0, SAD outputs 0, `tag_A` 0, `tag_B` = TAG_STEP.
- Reset asserted mid-run returns to IDLE immediately. The partial result is discarded and no `done` is generated.
- `start` in cycle t: `pix_ready` is 1 in cycle t+1.
- Last pixel accepted in cycle t: `sad_valid` is 1 in cycle t+1. Pixel-to-result latency is 1 cycle.
- Outputs hold while `sad_valid & !sad_ready`. Backpressure is unlimited.
- Result accepted in cycle t:
  - if more pairs remain, `pix_ready`=1 in cycle t+1;
  - otherwise `done`=1 in cycle t+1 and `busy`=0 in cycle t+1.
- Throughput with no stalls: NPIX+1 cycles per pair.
- `pix_valid` gaps stall accumulation without loss. Data on non-accepted cycles is ignored.
- `busy`, `done`, `pix_ready` and `sad_valid` are all registered, decoded from state only. No combinational path from inputs to handshake outputs.

## Test plan
- Basic pair: NPIX=16, window=100, A=103, B=90, tag_base=0x1000, num_pairs=1 → A=48, B=160, tag_A=0x1000, tag_B=0x1004, `sad_valid` 1 cycle after the 16th pixel, `done` 1 cycle after acceptance.
- Multi-pair tags: num_pairs=3, tag_base=0x1000 → tag pairs (0x1000,0x1004), (0x1008,0x100C), (0x1010,0x1014), exactly one `done`.
- Max value: NPIX=32, window=0, A=255, B=255 → A=B=8160, no wrap.
- Backpressure and gaps:
  - random `pix_valid` gaps give the same sums as the gap-free run;
  - `sad_ready` held low for 10 cycles keeps outputs stable and `pix_ready`=0.
- num_pairs=0 → no `sad_valid`, `done` pulses one cycle after `start`. `start` pulsed during ACCUM has no effect.
- Reset asserted after pixel 7 of a pair → all outputs at reset values at once; a new run afterwards produces correct sums with no carry-over.

Source files
------------

// File: rtl/sad_pair_engine.sv
// Dual-candidate SAD engine: accumulates |A-W| and |B-W| over NPIX pixel triples
// and presents tagged result pairs on a valid/ready handshake, num_pairs per start.
module sad_pair_engine #(
    parameter int NPIX     = 16,
    parameter int TAG_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] tag_base,
    input  logic [7:0]  num_pairs,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  window_pix,
    input  logic [7:0]  frame_pix_A,
    input  logic [7:0]  frame_pix_B,
    output logic        sad_valid,
    input  logic        sad_ready,
    output logic [12:0] SAD_value_small_A,
    output logic [12:0] SAD_value_small_B,
    output logic [31:0] tag_A,
    output logic [31:0] tag_B,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = $clog2(NPIX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]       state;
    logic [12:0]      acc_a;
    logic [12:0]      acc_b;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       pairs_left;
    logic [31:0]      tag_a_r;
    logic             done_r;

    logic [7:0] diff_a;
    logic [7:0] diff_b;
    logic       pix_fire;
    logic       sad_fire;
    logic       last_pix;

    always_comb begin
        diff_a   = (frame_pix_A >= window_pix) ? (frame_pix_A - window_pix)
                                               : (window_pix - frame_pix_A);
        diff_b   = (frame_pix_B >= window_pix) ? (frame_pix_B - window_pix)
                                               : (window_pix - frame_pix_B);
        pix_fire = pix_valid && (state == S_ACCUM);
        sad_fire = sad_ready && (state == S_OUT);
        last_pix = (pix_cnt == CNT_W'(NPIX - 1));
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign pix_ready         = (state == S_ACCUM);
    assign sad_valid         = (state == S_OUT);
    assign busy              = (state != S_IDLE);
    assign done              = done_r;
    assign SAD_value_small_A = acc_a;
    assign SAD_value_small_B = acc_b;
    assign tag_A             = tag_a_r;
    assign tag_B             = tag_a_r + 32'(TAG_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc_a      <= '0;
            acc_b      <= '0;
            pix_cnt    <= '0;
            pairs_left <= '0;
            tag_a_r    <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tag_a_r    <= tag_base;
                        pairs_left <= num_pairs;
                        acc_a      <= '0;
                        acc_b      <= '0;
                        pix_cnt    <= '0;
                        if (num_pairs == 8'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (pix_fire) begin
                        acc_a   <= acc_a + {5'd0, diff_a};
                        acc_b   <= acc_b + {5'd0, diff_b};
                        pix_cnt <= pix_cnt + 1'b1;
                        if (last_pix) begin
                            state <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (sad_fire) begin
                        pairs_left <= pairs_left - 8'd1;
                        // A pair covers two adjacent candidates, so the next A skips past this B.
                        if (pairs_left > 8'd1) begin
                            tag_a_r <= tag_a_r + 32'(2 * TAG_STEP);
                            acc_a   <= '0;
                            acc_b   <= '0;
                            pix_cnt <= '0;
                            state   <= S_ACCUM;
                        end else begin
                            state  <= S_IDLE;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
